// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-through bypass and a per-register pending
// scoreboard (reserved at issue, cleared at writeback) plus an outstanding-reservation count.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic              reg_write_in,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reserve_in,
    input  logic [ADDR_W-1:0] reserve_addr,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    output logic              equal,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic [ADDR_W:0]   pending_count
);

    localparam int unsigned NREGS = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam bit          HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic [NREGS-1:0]  pending_next;

    logic we;
    logic re;
    logic rs_hit;
    logic rt_hit;
    logic cnt_inc;
    logic cnt_dec;

    // Qualified strobes: reset and the hardwired zero register suppress both.
    always_comb begin
        we = reg_write_in && !reset && !(HAS_ZERO && (write_addr == '0));
        re = reserve_in && !reset && !(HAS_ZERO && (reserve_addr == '0));
    end

    always_comb begin
        rs_hit = we && (write_addr == rs_addr);
        rt_hit = we && (write_addr == rt_addr);
    end

    // Operand reads with same-cycle write-through from the writeback port.
    always_comb begin
        read_data_1 = regs[rs_addr];
        if (rs_hit) begin
            read_data_1 = write_data;
        end
        if (HAS_ZERO && (rs_addr == '0)) begin
            read_data_1 = '0;
        end

        read_data_2 = regs[rt_addr];
        if (rt_hit) begin
            read_data_2 = write_data;
        end
        if (HAS_ZERO && (rt_addr == '0)) begin
            read_data_2 = '0;
        end
    end

    assign equal = (read_data_1 == read_data_2);

    // A writeback in flight releases its consumer immediately; a new reserve only shows next cycle.
    always_comb begin
        rs_busy = pending[rs_addr] && !rs_hit;
        rt_busy = pending[rt_addr] && !rt_hit;
    end

    // Reserve is applied after the clear so a newly issued producer keeps the bit set.
    always_comb begin
        pending_next = pending;
        if (we) begin
            pending_next[write_addr] = 1'b0;
        end
        if (re) begin
            pending_next[reserve_addr] = 1'b1;
        end
    end

    // Incremental popcount: +1 only for a newly set bit, -1 only for a real clear not overridden.
    always_comb begin
        cnt_inc = re && !pending[reserve_addr];
        cnt_dec = we && pending[write_addr] && !(re && (reserve_addr == write_addr));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[write_addr] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_count <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   pending_count <= pending_count + CNT_W'(1);
                2'b01:   pending_count <= pending_count - CNT_W'(1);
                default: pending_count <= pending_count;
            endcase
        end
    end

endmodule
